varredor_mux4: RTL and testbench

- Sequential scan controller sitting directly around the 4:1 datapath multiplexer (mux4_1).
- Drives that mux's select lines and consumes its output.
- On a start pulse, steps sel through slots 0..last and waits a programmable settle time per slot.
- Captures each selected word into a register and offers it downstream over a valid/accept handshake, then pulses pronto.

---
 rtl/varredor_mux4_pkg.sv | 17 +
 rtl/varredor_mux4_if.sv | 38 +++
 rtl/varredor_mux4_contador_espera.sv | 33 +++
 rtl/varredor_mux4.sv | 126 ++++++++++++
 tb/tb_varredor_mux4.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/varredor_mux4_pkg.sv
// Shared definitions for the varredor_mux4 scan controller:
// state encoding and default widths / settle time.
package varredor_mux4_pkg;

  localparam int unsigned DEFAULT_SIZE = 64;
  localparam int unsigned DEFAULT_HOLD = 4;
  localparam int unsigned DEFAULT_CW   = 8;
  localparam int unsigned SEL_W        = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SELECIONA = 2'b01,
    OFERECE   = 2'b10,
    FIM       = 2'b11
  } estado_t;

endpackage

// File: rtl/varredor_mux4_if.sv
// Bus between the scan controller and its environment.
//   iniciar     : start request
//   num_slots   : index of the last slot to scan
//   mux_data_i  : mux data output for the current sel
//   aceito_i    : downstream accept
//   sel         : mux select
//   dado_o      : captured word
//   dado_valido : dado_o holds an unaccepted word
//   ocupado     : controller busy
//   pronto      : one-cycle scan-done pulse
// master = controller side, slave = environment side.
interface varredor_mux4_if
  import varredor_mux4_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE
);

  logic             iniciar;
  logic [SEL_W-1:0] num_slots;
  logic [SIZE-1:0]  mux_data_i;
  logic             aceito_i;
  logic [SEL_W-1:0] sel;
  logic [SIZE-1:0]  dado_o;
  logic             dado_valido;
  logic             ocupado;
  logic             pronto;

  modport master (
    input  iniciar, num_slots, mux_data_i, aceito_i,
    output sel, dado_o, dado_valido, ocupado, pronto
  );

  modport slave (
    output iniciar, num_slots, mux_data_i, aceito_i,
    input  sel, dado_o, dado_valido, ocupado, pronto
  );

endinterface

// File: rtl/varredor_mux4_contador_espera.sv
// Settle counter: counts up while enabled, clears on request,
// flags terminal count at HOLD-1.
//   clock, reset_n : clock and synchronous active-low reset
//   i_clr          : synchronous clear (priority over i_en)
//   i_en           : count enable
//   o_tc_c         : combinational terminal-count flag
module contador_espera #(
  parameter int unsigned CW   = 8,
  parameter int unsigned HOLD = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [CW-1:0] r_cnt;

  // Counter register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc_c = (r_cnt == CW'(HOLD - 1));

endmodule

// File: rtl/varredor_mux4.sv
// Scan controller around a 4:1 datapath mux: on iniciar it steps sel
// through slots 0..last, waits HOLD cycles per slot, captures the mux
// output and offers it downstream on a valid/accept handshake, then
// pulses pronto.
//   clock, reset_n : clock and synchronous active-low reset
//   bus (master)   : iniciar/num_slots/mux_data_i/aceito_i in,
//                    sel/dado_o/dado_valido/ocupado/pronto out
module varredor_mux4
  import varredor_mux4_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE,
  parameter int unsigned HOLD = DEFAULT_HOLD,
  parameter int unsigned CW   = DEFAULT_CW
) (
  input  logic           clock,
  input  logic           reset_n,
  varredor_mux4_if.master bus
);

  estado_t          r_estado, w_estado_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic [SEL_W-1:0] r_last, w_last_nxt;
  logic [SIZE-1:0]  r_dado, w_dado_nxt;
  logic             r_valido, w_valido_nxt;
  logic             r_pronto, w_pronto_nxt;

  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  // Counter only runs in SELECIONA and is zero on every entry into it
  assign w_cnt_clr = (r_estado != SELECIONA);
  assign w_cnt_en  = (r_estado == SELECIONA) && !w_tc;

  contador_espera #(
    .CW   (CW),
    .HOLD (HOLD)
  ) u_contador (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_tc_c  (w_tc)
  );

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_estado <= IDLE;
      r_sel    <= '0;
      r_idx    <= '0;
      r_last   <= '0;
      r_dado   <= '0;
      r_valido <= 1'b0;
      r_pronto <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_sel    <= w_sel_nxt;
      r_idx    <= w_idx_nxt;
      r_last   <= w_last_nxt;
      r_dado   <= w_dado_nxt;
      r_valido <= w_valido_nxt;
      r_pronto <= w_pronto_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_estado_nxt = r_estado;
    w_sel_nxt    = r_sel;
    w_idx_nxt    = r_idx;
    w_last_nxt   = r_last;
    w_dado_nxt   = r_dado;
    w_valido_nxt = r_valido;
    w_pronto_nxt = 1'b0;

    unique case (r_estado)
      IDLE: begin
        if (bus.iniciar) begin
          w_last_nxt   = bus.num_slots;
          w_idx_nxt    = '0;
          w_sel_nxt    = '0;
          w_estado_nxt = SELECIONA;
        end
      end

      SELECIONA: begin
        if (w_tc) begin
          w_dado_nxt   = bus.mux_data_i;
          w_valido_nxt = 1'b1;
          w_estado_nxt = OFERECE;
        end
      end

      OFERECE: begin
        if (bus.aceito_i) begin
          w_valido_nxt = 1'b0;
          if (r_idx != r_last) begin
            w_idx_nxt    = r_idx + SEL_W'(1);
            w_sel_nxt    = r_idx + SEL_W'(1);
            w_estado_nxt = SELECIONA;
          end else begin
            w_pronto_nxt = 1'b1;
            w_estado_nxt = FIM;
          end
        end
      end

      FIM: begin
        w_estado_nxt = IDLE;
      end

      default: begin
        w_estado_nxt = IDLE;
      end
    endcase
  end

  assign bus.sel         = r_sel;
  assign bus.dado_o      = r_dado;
  assign bus.dado_valido = r_valido;
  assign bus.pronto      = r_pronto;
  assign bus.ocupado     = (r_estado != IDLE);

endmodule

// File: tb/tb_varredor_mux4.sv
// Bench for varredor_mux4: HOLD=4 and HOLD=1 instances, each fed by a
// 4:1 mux model with inputs A0/B1/C2/D3. A scoreboard queue per instance
// holds expected (sel, word) pairs popped by a monitor on each handshake.
module tb_varredor_mux4;
  import varredor_mux4_pkg::*;

  localparam int unsigned SIZE = 64;
  localparam logic [SIZE-1:0] ENTRADA [4] = '{64'hA0, 64'hB1, 64'hC2, 64'hD3};

  typedef struct packed {
    logic [1:0]      sel;
    logic [SIZE-1:0] dado;
  } esperado_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  varredor_mux4_if #(.SIZE(SIZE)) ifa ();
  varredor_mux4_if #(.SIZE(SIZE)) ifb ();

  varredor_mux4 #(.SIZE(SIZE), .HOLD(4), .CW(8)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  varredor_mux4 #(.SIZE(SIZE), .HOLD(1), .CW(8)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  // mux4_1 models
  always_comb ifa.mux_data_i = ENTRADA[ifa.sel];
  always_comb ifb.mux_data_i = ENTRADA[ifb.sel];

  esperado_t qa[$];
  esperado_t qb[$];

  int n_vec_s  = 0;
  int n_miss_s = 0;
  int n_vec_m  = 0;
  int n_miss_m = 0;
  int pronto_a = 0;
  int pronto_b = 0;

  // Monitor: pop and compare on every accepted word
  always @(negedge clock) begin
    esperado_t e;
    if (reset_n && ifa.dado_valido && ifa.aceito_i) begin
      n_vec_m++;
      if (qa.size() == 0) begin
        n_miss_m++;
        $display("FAIL a_handshake: got sel=%0d dado=%h, expected no word", ifa.sel, ifa.dado_o);
      end else begin
        e = qa.pop_front();
        if (ifa.dado_o !== e.dado || ifa.sel !== e.sel) begin
          n_miss_m++;
          $display("FAIL a_handshake: got sel=%0d dado=%h, expected sel=%0d dado=%h",
                   ifa.sel, ifa.dado_o, e.sel, e.dado);
        end
      end
    end
    if (reset_n && ifb.dado_valido && ifb.aceito_i) begin
      n_vec_m++;
      if (qb.size() == 0) begin
        n_miss_m++;
        $display("FAIL b_handshake: got sel=%0d dado=%h, expected no word", ifb.sel, ifb.dado_o);
      end else begin
        e = qb.pop_front();
        if (ifb.dado_o !== e.dado || ifb.sel !== e.sel) begin
          n_miss_m++;
          $display("FAIL b_handshake: got sel=%0d dado=%h, expected sel=%0d dado=%h",
                   ifb.sel, ifb.dado_o, e.sel, e.dado);
        end
      end
    end
    if (ifa.pronto) pronto_a++;
    if (ifb.pronto) pronto_b++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec_s++;
    if (act !== exp) begin
      n_miss_s++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    n_vec_s++;
    if (act !== exp) begin
      n_miss_s++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec_s++;
    if (act !== exp) begin
      n_miss_s++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_a(input int first, input int last);
    for (int s = first; s <= last; s++) qa.push_back({2'(s), ENTRADA[s]});
  endtask

  task automatic start_a(input logic [1:0] ns);
    ifa.num_slots = ns;
    ifa.iniciar   = 1'b1;
    step();
    ifa.iniciar   = 1'b0;
  endtask

  task automatic wait_valid_a(input string nm);
    int n = 0;
    while (!ifa.dado_valido && n < 50) begin
      step();
      n++;
    end
    chk1(nm, ifa.dado_valido, 1'b1);
  endtask

  task automatic wait_idle_a(input string nm);
    int n = 0;
    while (ifa.ocupado && n < 200) begin
      step();
      n++;
    end
    chk1(nm, ifa.ocupado, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_n       = 1'b0;
    ifa.iniciar   = 1'b0;
    ifa.num_slots = 2'd0;
    ifa.aceito_i  = 1'b0;
    ifb.iniciar   = 1'b0;
    ifb.num_slots = 2'd0;
    ifb.aceito_i  = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    chki("rst_a_sel", int'(ifa.sel), 0);
    chk64("rst_a_dado", ifa.dado_o, '0);
    chk1("rst_a_valido", ifa.dado_valido, 1'b0);
    chk1("rst_a_ocupado", ifa.ocupado, 1'b0);
    chk1("rst_a_pronto", ifa.pronto, 1'b0);
    chk1("rst_b_ocupado", ifb.ocupado, 1'b0);
    chk1("rst_b_valido", ifb.dado_valido, 1'b0);

    // Full scan with immediate accepts, exact cycle timing
    push_a(0, 3);
    p0 = pronto_a;
    ifa.aceito_i = 1'b1;
    start_a(2'd3);
    chk1("full_t0_ocupado", ifa.ocupado, 1'b1);
    chk1("full_t0_valido", ifa.dado_valido, 1'b0);
    for (int k = 1; k <= 21; k++) begin
      step();
      chk1($sformatf("full_t%0d_valido", k), ifa.dado_valido,
           (k == 4) || (k == 9) || (k == 14) || (k == 19));
      chk1($sformatf("full_t%0d_pronto", k), ifa.pronto, k == 20);
      chk1($sformatf("full_t%0d_ocupado", k), ifa.ocupado, k <= 20);
      chki($sformatf("full_t%0d_sel", k), int'(ifa.sel), (k / 5 > 3) ? 3 : k / 5);
    end
    ifa.aceito_i = 1'b0;
    chki("full_pronto_pulses", pronto_a - p0, 1);
    chki("full_queue_drained", qa.size(), 0);

    // Backpressure on slot 1
    push_a(0, 3);
    p0 = pronto_a;
    start_a(2'd3);
    wait_valid_a("bp_slot0_wait");
    ifa.aceito_i = 1'b1;
    step();
    ifa.aceito_i = 1'b0;
    wait_valid_a("bp_slot1_wait");
    for (int i = 0; i < 10; i++) begin
      chk64($sformatf("bp_hold%0d_dado", i), ifa.dado_o, 64'hB1);
      chki($sformatf("bp_hold%0d_sel", i), int'(ifa.sel), 1);
      chk1($sformatf("bp_hold%0d_valido", i), ifa.dado_valido, 1'b1);
      step();
    end
    ifa.aceito_i = 1'b1;
    step();
    ifa.aceito_i = 1'b0;
    chk1("bp_after_accept_valido", ifa.dado_valido, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk1($sformatf("bp_slot2_ta%0d_valido", j), ifa.dado_valido, j == 4);
    end
    chk64("bp_slot2_dado", ifa.dado_o, 64'hC2);
    chki("bp_slot2_sel", int'(ifa.sel), 2);
    ifa.aceito_i = 1'b1;
    wait_idle_a("bp_finish");
    ifa.aceito_i = 1'b0;
    chki("bp_pronto_pulses", pronto_a - p0, 1);
    chki("bp_queue_drained", qa.size(), 0);

    // Ignored inputs: iniciar/num_slots mid-scan, accept in SELECIONA
    push_a(0, 3);
    p0 = pronto_a;
    start_a(2'd3);
    ifa.num_slots = 2'd1;
    ifa.iniciar   = 1'b1;
    step();
    ifa.aceito_i  = 1'b1;
    step();
    ifa.aceito_i  = 1'b0;
    ifa.iniciar   = 1'b0;
    chk1("ign_t2_valido", ifa.dado_valido, 1'b0);
    step();
    chk1("ign_t3_valido", ifa.dado_valido, 1'b0);
    step();
    chk1("ign_t4_valido", ifa.dado_valido, 1'b1);
    chki("ign_t4_sel", int'(ifa.sel), 0);
    ifa.aceito_i = 1'b1;
    wait_idle_a("ign_finish");
    ifa.aceito_i = 1'b0;
    chki("ign_pronto_pulses", pronto_a - p0, 1);
    chki("ign_queue_drained", qa.size(), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("ign_no_restart%0d", i), ifa.ocupado, 1'b0);
    end

    // Reset while offering slot 2
    push_a(0, 1);
    start_a(2'd3);
    wait_valid_a("rstm_slot0_wait");
    ifa.aceito_i = 1'b1;
    step();
    ifa.aceito_i = 1'b0;
    wait_valid_a("rstm_slot1_wait");
    ifa.aceito_i = 1'b1;
    step();
    ifa.aceito_i = 1'b0;
    wait_valid_a("rstm_slot2_wait");
    chki("rstm_pre_sel", int'(ifa.sel), 2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chki("rstm_sel", int'(ifa.sel), 0);
    chk64("rstm_dado", ifa.dado_o, '0);
    chk1("rstm_valido", ifa.dado_valido, 1'b0);
    chk1("rstm_ocupado", ifa.ocupado, 1'b0);
    chk1("rstm_pronto", ifa.pronto, 1'b0);
    chki("rstm_queue_drained", qa.size(), 0);
    push_a(0, 3);
    p0 = pronto_a;
    ifa.aceito_i = 1'b1;
    start_a(2'd3);
    wait_idle_a("rstm_restart_finish");
    ifa.aceito_i = 1'b0;
    chki("rstm_restart_pronto", pronto_a - p0, 1);
    chki("rstm_restart_drained", qa.size(), 0);

    // Single slot, HOLD=1 instance
    qb.push_back({2'd0, ENTRADA[0]});
    ifb.num_slots = 2'd0;
    ifb.iniciar   = 1'b1;
    step();
    ifb.iniciar   = 1'b0;
    chk1("h1_t0_valido", ifb.dado_valido, 1'b0);
    chk1("h1_t0_ocupado", ifb.ocupado, 1'b1);
    step();
    chk1("h1_t1_valido", ifb.dado_valido, 1'b1);
    chk64("h1_t1_dado", ifb.dado_o, 64'hA0);
    chki("h1_t1_sel", int'(ifb.sel), 0);
    ifb.aceito_i = 1'b1;
    step();
    ifb.aceito_i = 1'b0;
    chk1("h1_t2_pronto", ifb.pronto, 1'b1);
    chk1("h1_t2_valido", ifb.dado_valido, 1'b0);
    chki("h1_t2_sel", int'(ifb.sel), 0);
    step();
    chk1("h1_t3_pronto", ifb.pronto, 1'b0);
    chk1("h1_t3_ocupado", ifb.ocupado, 1'b0);
    chki("h1_t3_sel", int'(ifb.sel), 0);
    chki("h1_pronto_pulses", pronto_b, 1);
    chki("h1_queue_drained", qb.size(), 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec_s + n_vec_m, n_miss_s + n_miss_m);
    $finish;
  end

endmodule
